// File: rtl/async_fifo_core_if.sv
// rtl/async_fifo_core_if.sv - FIFO producer/consumer bundle; ASYNC_FIFO_CORE_LEVEL_EN adds level outputs
interface async_fifo_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
`ifdef ASYNC_FIFO_CORE_LEVEL_EN
    logic [ADDR_WIDTH:0]   level;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, level, almost_full, almost_empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, level, almost_full, almost_empty
    );
`else
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty
    );
`endif
endinterface

// File: rtl/async_fifo_core.sv
// rtl/async_fifo_core.sv - single-clock FIFO with full/empty flags; ASYNC_FIFO_CORE_LEVEL_EN adds level/almost flags
module async_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    async_fifo_core_if.slave fifo_if
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic rd_accept;

    // Status flags from registered pointers; gating keeps overflow/underflow harmless.
    always_comb begin
        empty_w   = (wr_ptr_q == rd_ptr_q);
        full_w    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        wr_accept = fifo_if.wr_en && !full_w;
        rd_accept = fifo_if.rd_en && !empty_w;
    end

    // Next pointer and read-data values; rd_data holds unless a read is accepted.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Pointer and read-data registers; reset discards stored data at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array is deliberately not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_if.wr_data;
        end
    end

    assign fifo_if.rd_data = rd_data_q;
    assign fifo_if.full    = full_w;
    assign fifo_if.empty   = empty_w;

`ifdef ASYNC_FIFO_CORE_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [ADDR_WIDTH:0] level_w;
    logic                almost_full_w;
    logic                almost_empty_w;

    // Occupancy is the modular pointer difference, so wrap needs no special case.
    always_comb begin
        level_w        = wr_ptr_q - rd_ptr_q;
        almost_full_w  = (level_w >= AF_LEVEL);
        almost_empty_w = (level_w <= PTR_ONE);
    end

    assign fifo_if.level        = level_w;
    assign fifo_if.almost_full  = almost_full_w;
    assign fifo_if.almost_empty = almost_empty_w;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// tb/tb_async_fifo_core.sv - self-checking bench for async_fifo_core against a queue model
module tb_async_fifo_core;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic reset_n;

    async_fifo_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if ();

    async_fifo_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fifo_if (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [7:0] model_q [$];
    logic [7:0] model_rd;

    // Drive one clock of stimulus and advance the reference model by the FIFO rules.
    task automatic tick(input logic w, input logic [7:0] wd, input logic r);
        bit m_full;
        bit m_empty;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        fifo_if.wr_en   = w;
        fifo_if.wr_data = wd;
        fifo_if.rd_en   = r;
        @(posedge clk);
        #1;
        if (r && !m_empty) model_rd = model_q.pop_front();
        if (w && !m_full) model_q.push_back(wd);
        fifo_if.wr_en   = 1'b0;
        fifo_if.rd_en   = 1'b0;
        fifo_if.wr_data = 8'($urandom);
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        fifo_if.wr_en   = 1'b0;
        fifo_if.rd_en   = 1'b0;
        fifo_if.wr_data = 8'h00;
        model_q.delete();
        model_rd = 8'h00;
        #20;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #2;
        vectors++;
        if (fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_empty got %b want 1", fifo_if.empty);
        end
        vectors++;
        if (fifo_if.full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_full got %b want 0", fifo_if.full);
        end
        vectors++;
        if (fifo_if.rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rd_data got %h want 00", fifo_if.rd_data);
        end
`ifdef ASYNC_FIFO_CORE_LEVEL_EN
        vectors++;
        if (fifo_if.level !== 5'd0 || fifo_if.almost_full !== 1'b0 || fifo_if.almost_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_level got %0d/%b/%b want 0/0/1", fifo_if.level, fifo_if.almost_full, fifo_if.almost_empty);
        end
`endif
    endtask

    task automatic test_single();
        tick(1'b1, 8'hAA, 1'b0);
        vectors++;
        if (fifo_if.empty !== 1'b0) begin
            miscompares++;
            $display("FAIL single_empty_after_write got %b want 0", fifo_if.empty);
        end
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== 8'hAA) begin
            miscompares++;
            $display("FAIL single_rd_data got %h want aa", fifo_if.rd_data);
        end
        vectors++;
        if (fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_empty_after_read got %b want 1", fifo_if.empty);
        end
    endtask

    task automatic test_interleave();
        logic [7:0] vals [7];
        vals = '{8'h55, 8'h22, 8'h27, 8'h33, 8'h00, 8'h77, 8'h15};
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, vals[i], 1'b0);
            tick(1'b0, 8'h00, 1'b1);
            vectors++;
            if (fifo_if.rd_data !== vals[i] || fifo_if.full !== 1'b0) begin
                miscompares++;
                $display("FAIL interleave[%0d] got data %h full %b want data %h full 0", i, fifo_if.rd_data, fifo_if.full, vals[i]);
            end
        end
        vectors++;
        if (fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL interleave_end_empty got %b want 1", fifo_if.empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            vectors++;
            if (fifo_if.full !== (i == DEPTH - 1)) begin
                miscompares++;
                $display("FAIL fill_full[%0d] got %b want %b", i, fifo_if.full, (i == DEPTH - 1));
            end
        end
        tick(1'b1, 8'hFF, 1'b0);
        vectors++;
        if (fifo_if.full !== 1'b1 || fifo_if.empty !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_overflow got full %b empty %b want full 1 empty 0", fifo_if.full, fifo_if.empty);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            vectors++;
            if (fifo_if.rd_data !== 8'(i) || fifo_if.full !== 1'b0) begin
                miscompares++;
                $display("FAIL drain[%0d] got data %h full %b want data %h full 0", i, fifo_if.rd_data, fifo_if.full, 8'(i));
            end
        end
        vectors++;
        if (fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end_empty got %b want 1", fifo_if.empty);
        end
    endtask

    task automatic test_read_empty();
        logic [7:0] prior;
        prior = model_rd;
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== prior || fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL read_empty_hold got %h empty %b want %h empty 1", fifo_if.rd_data, fifo_if.empty, prior);
        end
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== 8'h3C || fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL read_empty_ptr got %h empty %b want 3c empty 1", fifo_if.rd_data, fifo_if.empty);
        end
    endtask

    task automatic test_simul_empty();
        logic [7:0] prior;
        prior = model_rd;
        tick(1'b1, 8'h6B, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== prior || fifo_if.empty !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_empty got %h empty %b want %h empty 0", fifo_if.rd_data, fifo_if.empty, prior);
        end
        tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== 8'h6B || fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_empty_read got %h empty %b want 6b empty 1", fifo_if.rd_data, fifo_if.empty);
        end
    endtask

    task automatic test_simul_mid();
        for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'($urandom), 1'b1);
            vectors++;
            if (fifo_if.rd_data !== model_rd || fifo_if.full !== 1'b0 || fifo_if.empty !== 1'b0 || model_q.size() != 8) begin
                miscompares++;
                $display("FAIL simul_mid[%0d] got %h f%b e%b want %h f0 e0", i, fifo_if.rd_data, fifo_if.full, fifo_if.empty, model_rd);
            end
`ifdef ASYNC_FIFO_CORE_LEVEL_EN
            vectors++;
            if (fifo_if.level !== 5'd8) begin
                miscompares++;
                $display("FAIL simul_mid_level got %0d want 8", fifo_if.level);
            end
`endif
        end
        while (model_q.size() > 0) begin
            tick(1'b0, 8'h00, 1'b1);
            vectors++;
            if (fifo_if.rd_data !== model_rd) begin
                miscompares++;
                $display("FAIL simul_mid_drain got %h want %h", fifo_if.rd_data, model_rd);
            end
        end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(8'h80 + i), 1'b0);
        tick(1'b1, 8'hEE, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== 8'h80 || fifo_if.full !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_full got %h full %b want 80 full 0", fifo_if.rd_data, fifo_if.full);
        end
        for (int i = 1; i < DEPTH; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            vectors++;
            if (fifo_if.rd_data !== 8'(8'h80 + i)) begin
                miscompares++;
                $display("FAIL simul_full_drain[%0d] got %h want %h", i, fifo_if.rd_data, 8'(8'h80 + i));
            end
        end
        vectors++;
        if (fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_full_end_empty got %b want 1", fifo_if.empty);
        end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        int   wprob;
        for (int i = 0; i < 400; i++) begin
            wprob = ((i / 50) % 2 == 0) ? 80 : 20;
            w = ($urandom_range(0, 99) < wprob);
            r = ($urandom_range(0, 99) < (100 - wprob));
            tick(w, 8'($urandom), r);
            vectors++;
            if (fifo_if.rd_data !== model_rd ||
                fifo_if.full !== (model_q.size() == DEPTH) ||
                fifo_if.empty !== (model_q.size() == 0)) begin
                miscompares++;
                $display("FAIL random[%0d] got %h f%b e%b want %h f%b e%b", i, fifo_if.rd_data, fifo_if.full, fifo_if.empty,
                         model_rd, (model_q.size() == DEPTH), (model_q.size() == 0));
            end
`ifdef ASYNC_FIFO_CORE_LEVEL_EN
            vectors++;
            if (fifo_if.level !== 5'(model_q.size()) ||
                fifo_if.almost_full !== (model_q.size() >= DEPTH - 1) ||
                fifo_if.almost_empty !== (model_q.size() <= 1)) begin
                miscompares++;
                $display("FAIL random_level[%0d] got %0d/%b/%b want %0d", i, fifo_if.level, fifo_if.almost_full,
                         fifo_if.almost_empty, model_q.size());
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h12, 1'b0);
        tick(1'b1, 8'h13, 1'b1);
        #3;
        reset_n = 1'b0;
        model_q.delete();
        model_rd = 8'h00;
        #1;
        vectors++;
        if (fifo_if.empty !== 1'b1 || fifo_if.rd_data !== 8'h00 || fifo_if.full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got empty %b data %h full %b want 1 00 0", fifo_if.empty, fifo_if.rd_data, fifo_if.full);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (fifo_if.rd_data !== 8'h5A || fifo_if.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_after got %h empty %b want 5a empty 1", fifo_if.rd_data, fifo_if.empty);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_interleave();
        test_fill();
        test_read_empty();
        test_simul_empty();
        test_simul_mid();
        test_simul_full();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
